vram_arbiter: RTL and testbench

Two-port front end for the 64K x 8 video RAM. It arbitrates each cycle between the display fetch port, which is read-only and normally has priority, and the host port, which can read or write. The winning request is driven onto the RAM's address, data and write-enable inputs, and read returns are tracked through the RAM's fixed two-edge read latency and steered back to the port that issued them. The block sits directly upstream of the VRAM and is its only master.

---
 rtl/vram_arbiter.sv | 115 +++++++++++
 tb/tb_vram_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: two-port front end for the 64K x 8 video RAM.
// Display fetch (read-only) normally wins. The host (read/write) is
// promoted after STARVE_LIMIT consecutive contended display grants.
// Read returns are tagged with their owner and steered back after the
// RAM's two-edge read latency.
// Optional feature macro: VRAM_ARB_RDATA_REG_EN registers mem_rdata
// before it reaches the ports. This adds one cycle of read latency.
module vram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        disp_req,
  input  logic [15:0] disp_addr,
  output logic        disp_ack,
  output logic        disp_rvalid,
  output logic [7:0]  disp_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic        host_rvalid,
  output logic [7:0]  host_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

`ifdef VRAM_ARB_RDATA_REG_EN
  localparam int NSTG = 3;
`else
  localparam int NSTG = 2;
`endif
  localparam int          LAST  = NSTG - 1;
  localparam logic [2:0]  LIMIT = 3'(STARVE_LIMIT);

  logic [2:0]      starve_cnt;
  logic            host_win;
  logic            push_vld;
  logic [NSTG-1:0] tag_vld;
  logic [NSTG-1:0] tag_host;
  logic [7:0]      ret_data;
  logic [7:0]      disp_hold;
  logic [7:0]      host_hold;

  // Grant decision: the host wins when it is alone or has been starved long
  // enough. Acks are held low while reset is asserted.
  always_comb begin
    host_win = host_req && (!disp_req || (starve_cnt == LIMIT));
    disp_ack = reset_n && disp_req && !host_win;
    host_ack = reset_n && host_win;
  end

  // Drive the RAM from the granted port. The display address is parked on the bus when idle.
  always_comb begin
    mem_addr  = host_ack ? host_addr : disp_addr;
    mem_wdata = host_wdata;
    mem_we    = host_ack && host_we;
    push_vld  = disp_ack || (host_ack && !host_we);
  end

  // Count display grants that passed over a waiting host. The count saturates at 7.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      starve_cnt <= 3'd0;
    else if (!host_req || host_ack)
      starve_cnt <= 3'd0;
    else if (disp_ack && (starve_cnt != 3'd7))
      starve_cnt <= starve_cnt + 3'd1;
  end

  // Tag pipe tracks {valid, owner} for reads in flight. Stage 0 is the newest.
  // Reset drops everything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld  <= '0;
      tag_host <= '0;
    end else begin
      tag_vld  <= {tag_vld[LAST-1:0], push_vld};
      tag_host <= {tag_host[LAST-1:0], host_ack};
    end
  end

`ifdef VRAM_ARB_RDATA_REG_EN
  logic [7:0] rd_q;
  // Retime the RAM output so the ports see a flop rather than the RAM's data path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_q <= 8'h00;
    else          rd_q <= mem_rdata;
  end
  assign ret_data = rd_q;
`else
  assign ret_data = mem_rdata;
`endif

  assign disp_rvalid = tag_vld[LAST] && !tag_host[LAST];
  assign host_rvalid = tag_vld[LAST] &&  tag_host[LAST];

  // Capture each returned byte so a port's rdata holds between its own returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_hold <= 8'h00;
      host_hold <= 8'h00;
    end else begin
      if (disp_rvalid) disp_hold <= ret_data;
      if (host_rvalid) host_hold <= ret_data;
    end
  end

  assign disp_rdata = disp_rvalid ? ret_data : disp_hold;
  assign host_rdata = host_rvalid ? ret_data : host_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter, with a behavioural 64K x 8 RAM model
// (the address is registered, and data appears after the second edge).
module tb_vram_arbiter;
`ifdef VRAM_ARB_RDATA_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_req, disp_ack, disp_rvalid;
  logic [15:0] disp_addr;
  logic [7:0]  disp_rdata;
  logic        host_req, host_we, host_ack, host_rvalid;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we;

  int total = 0;
  int bad   = 0;

  vram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: each byte holds its low address byte, except 0123, which holds A5.
  logic [7:0]  ram [0:65535];
  logic [15:0] ram_aq;
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = i[7:0];
    ram[16'h0123] = 8'hA5;
    ram_aq    = 16'h0000;
    mem_rdata = 8'h00;
  end
  always @(posedge clk) begin
    mem_rdata <= ram[ram_aq];
    ram_aq    <= mem_addr;
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  logic [6:0] pat;
  int r;

  initial begin
    // reset, with every request line active
    reset_n = 1'b0; disp_req = 1'b1; host_req = 1'b1; host_we = 1'b1;
    disp_addr = 16'h0; host_addr = 16'h0; host_wdata = 8'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dack", disp_ack, 0);    chk("rst_hack", host_ack, 0);
    chk("rst_we", mem_we, 0);        chk("rst_dvld", disp_rvalid, 0);
    chk("rst_hvld", host_rvalid, 0); chk("rst_drd", disp_rdata, 8'h00);
    chk("rst_hrd", host_rdata, 8'h00);

    // display-only read, acked in the first cycle after release
    cyc();
    reset_n = 1'b1; disp_req = 1'b1; disp_addr = 16'h0123; host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    chk("t1_dack", disp_ack, 1); chk("t1_hack", host_ack, 0); chk("t1_addr", mem_addr, 16'h0123);
    cyc(); disp_req = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk("t1_dvld", disp_rvalid, (k == LAT));
      chk("t1_hvld", host_rvalid, 0);
      if (k >= LAT) chk("t1_drd", disp_rdata, 8'hA5);
      chk("t1_hrd", host_rdata, 8'h00);
      cyc();
    end

    // interleaved display 0000..0003 / host 8000..8003
    for (int j = 0; j < 8 + LAT; j++) begin
      disp_req  = (j < 8) && (j % 2 == 0);
      host_req  = (j < 8) && (j % 2 == 1);
      host_we   = 1'b0;
      disp_addr = 16'(j / 2);
      host_addr = 16'h8000 + 16'(j / 2);
      @(negedge clk);
      if (j < 8) begin
        chk("il_dack", disp_ack, (j % 2 == 0));
        chk("il_hack", host_ack, (j % 2 == 1));
      end
      if (j >= LAT) begin
        r = j - LAT;
        if (r % 2 == 0) begin
          chk("il_dvld", disp_rvalid, 1); chk("il_hvld", host_rvalid, 0);
          chk("il_drd", disp_rdata, 16'(r / 2));
        end else begin
          chk("il_hvld", host_rvalid, 1); chk("il_dvld", disp_rvalid, 0);
          chk("il_hrd", host_rdata, 16'(r / 2));
        end
      end else begin
        chk("il_dvld0", disp_rvalid, 0); chk("il_hvld0", host_rvalid, 0);
      end
      cyc();
    end
    disp_req = 1'b0; host_req = 1'b0;

    // host write 3C to 8001, then read it back in the next cycle
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h8001; host_wdata = 8'h3C;
    @(negedge clk);
    chk("wr_hack", host_ack, 1); chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 16'h8001); chk("wr_data", mem_wdata, 8'h3C);
    cyc(); host_we = 1'b0;
    @(negedge clk);
    chk("rd_hack", host_ack, 1); chk("rd_we", mem_we, 0);
    cyc(); host_req = 1'b0;
    for (int k = 2; k <= LAT + 2; k++) begin
      @(negedge clk);
      chk("rw_hvld", host_rvalid, (k == LAT + 1));
      chk("rw_we", mem_we, 0);
      if (k == LAT + 1) chk("rw_hrd", host_rdata, 8'h3C);
      cyc();
    end

    // contention: four display grants, then one host grant, then display again
    pat = 7'b1101111;
    disp_req = 1'b1; host_req = 1'b1; host_we = 1'b0;
    disp_addr = 16'h0010; host_addr = 16'h0020;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("ct_dack", disp_ack, pat[i]);
      chk("ct_hack", host_ack, !pat[i]);
      cyc();
    end
    disp_req = 1'b0; host_req = 1'b0;
    repeat (LAT + 1) cyc();

    // bank edge: write 11 to 7FFF and 22 to 8000, then read both back to back
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h7FFF; host_wdata = 8'h11;
    @(negedge clk); chk("be_we", mem_we, 1);
    cyc(); host_addr = 16'h8000; host_wdata = 8'h22;
    cyc(); host_we = 1'b0; host_addr = 16'h7FFF;
    cyc(); host_addr = 16'h8000;
    cyc(); host_req = 1'b0;
    for (int k = 4; k <= LAT + 4; k++) begin
      @(negedge clk);
      chk("be_hvld", host_rvalid, (k == LAT + 2) || (k == LAT + 3));
      chk("be_dvld", disp_rvalid, 0);
      if (k == LAT + 2) chk("be_hrd0", host_rdata, 8'h11);
      if (k == LAT + 3) chk("be_hrd1", host_rdata, 8'h22);
      cyc();
    end

    // reset asserted one cycle after a display read is acked
    disp_req = 1'b1; disp_addr = 16'h0002;
    @(negedge clk); chk("mr_dack", disp_ack, 1);
    cyc(); reset_n = 1'b0; host_req = 1'b1; host_we = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mr_dack0", disp_ack, 0);    chk("mr_hack0", host_ack, 0);
      chk("mr_we", mem_we, 0);         chk("mr_dvld", disp_rvalid, 0);
      chk("mr_hvld", host_rvalid, 0);  chk("mr_drd", disp_rdata, 8'h00);
      chk("mr_hrd", host_rdata, 8'h00);
      cyc();
    end
    reset_n = 1'b1; disp_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
    repeat (LAT + 1) begin
      @(negedge clk); chk("mr_nodvld", disp_rvalid, 0);
      cyc();
    end
    disp_req = 1'b1; disp_addr = 16'h0003;
    @(negedge clk); chk("mr_dack2", disp_ack, 1);
    cyc(); disp_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("mr_dvld2", disp_rvalid, (k == LAT));
      if (k == LAT) chk("mr_drd2", disp_rdata, 8'h03);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
